transmit_connector: RTL and testbench

Streams the AGC I/O register file out over a byte-wide UART transmitter. The block steps through the I/O register selectors in turn and samples each 15-bit register through the shared `read_sel`/`io_reg_data` read port. It sends each value as a 6-byte frame of one header byte plus five ASCII octal digits, and runs continuously after reset. It sits between the core's I/O register read mux and the UART TX module.

---
 rtl/transmit_connector.sv | 111 +++++++++++
 tb/tb_transmit_connector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/transmit_connector.sv
// Scans the I/O register file and streams each register to a byte-wide UART
// as a header byte (0x80 | selector) followed by five ASCII octal digits.
package transmit_connector_pkg;
    typedef logic [3:0] IO_reg_t;
endpackage

module transmit_connector
    import transmit_connector_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        uart_tx_busy,
    input  logic [14:0] io_reg_data,
    output logic        uart_tx_en,
    output IO_reg_t     read_sel,
    output logic [7:0]  uart_tx_data
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SEND  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam IO_reg_t LAST_SEL = IO_reg_t'(NUM_REGS - 1);

    state_t      state_q, state_d;
    IO_reg_t     idx_q, idx_d;
    logic [14:0] word_q, word_d;
    logic [2:0]  k_q, k_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  frame_byte;

    // Byte k of the frame for the latched word; digits are 8'h30 + octal digit.
    always_comb begin
        frame_byte = 8'h00;
        case (k_q)
            3'd0:    frame_byte = 8'h80 | {4'h0, idx_q};
            3'd1:    frame_byte = 8'h30 + {5'b0, word_q[14:12]};
            3'd2:    frame_byte = 8'h30 + {5'b0, word_q[11:9]};
            3'd3:    frame_byte = 8'h30 + {5'b0, word_q[8:6]};
            3'd4:    frame_byte = 8'h30 + {5'b0, word_q[5:3]};
            default: frame_byte = 8'h30 + {5'b0, word_q[2:0]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        k_d       = k_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            LOAD: begin
                word_d  = io_reg_data;
                k_d     = 3'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = frame_byte;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (uart_tx_busy) state_d = DRAIN;
            end
            DRAIN: begin
                if (!uart_tx_busy) begin
                    if (k_q == 3'd5) begin
                        idx_d   = (idx_q == LAST_SEL) ? IO_reg_t'(0) : idx_q + IO_reg_t'(1);
                        state_d = LOAD;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            word_q    <= '0;
            k_q       <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            k_q       <= k_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign read_sel     = idx_q;

endmodule

// File: tb/tb_transmit_connector.sv
// Directed bench for transmit_connector (NUM_REGS = 3) with a small UART busy model.
module tb_transmit_connector;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        uart_tx_busy;
    logic [14:0] io_reg_data;
    logic        uart_tx_en;
    logic [3:0]  read_sel;
    logic [7:0]  uart_tx_data;

    logic [14:0] regval [0:3];

    always #5 clock = ~clock;

    assign io_reg_data = regval[read_sel[1:0]];

    transmit_connector #(.NUM_REGS(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .uart_tx_busy (uart_tx_busy),
        .io_reg_data  (io_reg_data),
        .uart_tx_en   (uart_tx_en),
        .read_sel     (read_sel),
        .uart_tx_data (uart_tx_data)
    );

    typedef struct {
        logic [3:0]      sel;
        logic [14:0]     val;
        int              mode;
        int              hold;
        logic [0:5][7:0] exp;
    } vec_t;

    vec_t vecs [5];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_en = -100;
    int mode = 0;   // 0 responsive, 1 toggle, 2 stuck high, 3 never busy
    int hold = 1;
    int cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge, then update the UART busy model.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (uart_tx_en) begin
            if (last_en >= 0) check("strobe spacing >=3", 32'(cyc - last_en >= 3), 32'd1);
            last_en = cyc;
        end
        case (mode)
            0: begin
                if (uart_tx_en) begin
                    uart_tx_busy = 1'b1;
                    cnt = hold;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) uart_tx_busy = 1'b0;
                end
            end
            1: uart_tx_busy = ~uart_tx_busy;
            2: uart_tx_busy = 1'b1;
            default: uart_tx_busy = 1'b0;
        endcase
    endtask

    task automatic set_mode(input int m, input int h);
        mode = m;
        hold = h;
        if (m == 0) begin
            uart_tx_busy = 1'b1;
            cnt = h;
        end
    endtask

    task automatic wait_strobe(output logic [7:0] b, output logic [3:0] sel);
        int n;
        n = 0;
        b = 8'h00;
        sel = 4'h0;
        do begin
            step();
            n++;
        end while (!uart_tx_en && n < 2000);
        if (!uart_tx_en) check("strobe timeout", 32'd0, 32'd1);
        else begin
            b = uart_tx_data;
            sel = read_sel;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] s;
        int seen;

        vecs[0] = '{4'd0, 15'o12345, 1, 0, {8'h80, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35}};
        vecs[1] = '{4'd1, 15'o07070, 0, 1, {8'h81, 8'h30, 8'h37, 8'h30, 8'h37, 8'h30}};
        vecs[2] = '{4'd2, 15'o77777, 0, 3, {8'h82, 8'h37, 8'h37, 8'h37, 8'h37, 8'h37}};
        vecs[3] = '{4'd0, 15'o00000, 0, 1, {8'h80, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30}};
        vecs[4] = '{4'd1, 15'o76543, 1, 0, {8'h81, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33}};
        for (int i = 0; i < 4; i++) regval[i] = 15'o0;

        reset_n = 1'b0;
        uart_tx_busy = 1'b0;
        mode = 3;
        step();
        step();
        check("reset tx_en", 32'(uart_tx_en), 32'd0);
        check("reset tx_data", 32'(uart_tx_data), 32'h00);
        check("reset read_sel", 32'(read_sel), 32'd0);

        for (int r = 0; r < 5; r++) begin
            regval[vecs[r].sel[1:0]] = vecs[r].val;
            if (r == 0) begin
                mode = vecs[r].mode;
                hold = vecs[r].hold;
                last_en = -100;
                reset_n = 1'b1;
            end else begin
                set_mode(vecs[r].mode, vecs[r].hold);
            end
            for (int j = 0; j < 6; j++) begin
                wait_strobe(b, s);
                check($sformatf("vec%0d byte%0d", r, j), 32'(b), 32'(vecs[r].exp[j]));
                if (j == 0) check($sformatf("vec%0d read_sel", r), 32'(s), 32'(vecs[r].sel));
            end
        end

        // Word is frozen once latched: zero the source right after the header.
        set_mode(0, 1);
        regval[2] = 15'o77777;
        wait_strobe(b, s);
        check("frozen header", 32'(b), 32'h82);
        regval[2] = 15'o00000;
        for (int j = 0; j < 5; j++) begin
            wait_strobe(b, s);
            check($sformatf("frozen digit%0d", j), 32'(b), 32'h37);
        end

        // Busy held high from reset: no strobe until busy drops, then exactly one cycle later.
        reset_n = 1'b0;
        mode = 2;
        uart_tx_busy = 1'b1;
        cnt = 0;
        step();
        step();
        reset_n = 1'b1;
        last_en = -100;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (uart_tx_en) seen++;
        end
        check("stuck busy strobes", 32'(seen), 32'd0);
        mode = 0;
        hold = 1;
        uart_tx_busy = 1'b0;
        step();
        check("busy release latency", 32'(uart_tx_en), 32'd1);
        check("busy release byte", 32'(uart_tx_data), 32'h80);

        // Finish selector 0 (value 0), then reset after byte 3 of selector 1.
        for (int j = 0; j < 5; j++) begin
            wait_strobe(b, s);
            check($sformatf("post-stall digit%0d", j), 32'(b), 32'h30);
        end
        for (int j = 0; j < 4; j++) begin
            wait_strobe(b, s);
            check($sformatf("pre-reset byte%0d", j), 32'(b), 32'(vecs[4].exp[j]));
        end
        reset_n = 1'b0;
        step();
        check("midframe reset tx_en", 32'(uart_tx_en), 32'd0);
        check("midframe reset read_sel", 32'(read_sel), 32'd0);
        reset_n = 1'b1;
        last_en = -100;
        wait_strobe(b, s);
        check("after reset header", 32'(b), 32'h80);
        check("after reset read_sel", 32'(s), 32'd0);

        // Busy never rises after a strobe: stuck in ACK.
        mode = 3;
        uart_tx_busy = 1'b0;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (uart_tx_en) seen++;
        end
        check("no ack strobes", 32'(seen), 32'd0);
        check("no ack read_sel", 32'(read_sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
